// File: rtl/t_counter.sv
// t_counter: modulo up/down counter built as a chain of toggle stages.
// Non-terminal steps flip the bits selected by a ripple toggle mask, so no
// adder is used. The terminal cases (wrap or saturate at either end of the
// range) and out-of-range recovery override the mask with a fixed value.
module t_counter #(
  parameter int WIDTH     = 4,
  parameter int MOD_VALUE = 10
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_sat,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD_VALUE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] t_up, t_dn;
  logic             at_max, at_zero, over;

  assign at_max  = (count_q == MAX);
  assign at_zero = (count_q == '0);
  assign over    = (count_q > MAX);

  // Toggle masks: bit k flips when all lower bits are 1 (up) or all 0 (down)
  always_comb begin
    t_up    = '0;
    t_dn    = '0;
    t_up[0] = 1'b1;
    t_dn[0] = 1'b1;
    for (int k = 1; k < WIDTH; k++) begin
      t_up[k] = t_up[k-1] &  count_q[k-1];
      t_dn[k] = t_dn[k-1] & ~count_q[k-1];
    end
  end

  // Next-state: load beats enable; terminal cases override the toggle mask
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (i_load) begin
      count_d = (i_load_val > MAX) ? MAX : i_load_val;
    end else if (i_en) begin
      if (over) begin
        // Recovery from an illegal state: snap to the start of travel
        count_d = i_up ? '0 : MAX;
      end else if (i_up) begin
        if (at_max) begin
          if (!i_sat) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q ^ t_up;
        end
      end else begin
        if (at_zero) begin
          if (!i_sat) begin
            count_d = MAX;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q ^ t_dn;
        end
      end
    end
  end

  // State registers; clear forces count and wrap low without a clock
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // Terminal count ignores saturate mode so it can enable the next stage
  assign o_tc    = i_en & (i_up ? at_max : at_zero);
  assign o_count = count_q;
  assign o_wrap  = wrap_q;

endmodule

// File: tb/tb_t_counter.sv
// Bench for t_counter: a driver issues directed vectors and queues the
// expected post-edge outputs; a monitor pops and compares after each edge.
module tb_t_counter;

  logic       clk = 1'b0;
  logic       i_clr, i_en, i_up, i_load, i_sat;
  logic [3:0] i_load_val;
  logic [3:0] o_count;
  logic       o_tc, o_wrap;

  // Cascade pair (00..99)
  logic       c_clr, c_en;
  logic [3:0] lo_count, hi_count;
  logic       lo_tc, hi_tc, lo_wrap, hi_wrap;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       casc;
    logic [3:0] cnt;
    logic       tc;
    logic       wr;
    logic [3:0] hi;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  t_counter #(.WIDTH(4), .MOD_VALUE(10)) dut (
    .i_clk(clk), .i_clr(i_clr), .i_en(i_en), .i_up(i_up), .i_load(i_load),
    .i_load_val(i_load_val), .i_sat(i_sat),
    .o_count(o_count), .o_tc(o_tc), .o_wrap(o_wrap)
  );

  t_counter #(.WIDTH(4), .MOD_VALUE(10)) u_lo (
    .i_clk(clk), .i_clr(c_clr), .i_en(c_en), .i_up(1'b1), .i_load(1'b0),
    .i_load_val(4'd0), .i_sat(1'b0),
    .o_count(lo_count), .o_tc(lo_tc), .o_wrap(lo_wrap)
  );

  t_counter #(.WIDTH(4), .MOD_VALUE(10)) u_hi (
    .i_clk(clk), .i_clr(c_clr), .i_en(lo_tc), .i_up(1'b1), .i_load(1'b0),
    .i_load_val(4'd0), .i_sat(1'b0),
    .o_count(hi_count), .o_tc(hi_tc), .o_wrap(hi_wrap)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the outputs
  // expected right after the following rising edge.
  task automatic step(input logic clr, input logic en, input logic up, input logic ld,
                      input logic [3:0] lv, input logic sat,
                      input logic [3:0] ec, input logic ew);
    exp_t e;
    @(negedge clk);
    i_clr = clr; i_en = en; i_up = up; i_load = ld; i_load_val = lv; i_sat = sat;
    e.casc = 1'b0;
    e.cnt  = ec;
    e.tc   = en & (up ? (ec == 4'd9) : (ec == 4'd0));
    e.wr   = ew;
    e.hi   = 4'd0;
    sbq.push_back(e);
  endtask

  task automatic cstep(input logic clr, input logic en,
                       input logic [3:0] elo, input logic [3:0] ehi, input logic ehw);
    exp_t e;
    @(negedge clk);
    c_clr = clr; c_en = en;
    e.casc = 1'b1;
    e.cnt  = elo;
    e.tc   = 1'b0;
    e.wr   = ehw;
    e.hi   = ehi;
    sbq.push_back(e);
  endtask

  // Monitor: sample just after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (!e.casc) begin
          chk("count", 16'(o_count), 16'(e.cnt));
          chk("tc",    16'(o_tc),    16'(e.tc));
          chk("wrap",  16'(o_wrap),  16'(e.wr));
        end else begin
          chk("casc_lo",   16'(lo_count), 16'(e.cnt));
          chk("casc_hi",   16'(hi_count), 16'(e.hi));
          chk("casc_hwrp", 16'(hi_wrap),  16'(e.wr));
        end
      end
    end
  end

  initial begin
    int t1[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    i_clr = 1'b1; i_en = 1'b1; i_up = 1'b1; i_load = 1'b0; i_load_val = 4'd0; i_sat = 1'b0;
    c_clr = 1'b1; c_en = 1'b0;

    // Reset state, and held through a rising edge with enable high
    #2;
    chk("rst_count", 16'(o_count), 16'd0);
    chk("rst_wrap",  16'(o_wrap),  16'd0);
    #5;
    chk("rst_hold",  16'(o_count), 16'd0);

    // Up with wrap
    foreach (t1[i]) step(0, 1, 1, 0, 4'd0, 0, 4'(t1[i]), (i == 9));

    // Load 2 then count down through zero
    step(0, 1, 1, 1, 4'd2, 0, 4'd2, 0);
    step(0, 1, 0, 0, 4'd0, 0, 4'd1, 0);
    step(0, 1, 0, 0, 4'd0, 0, 4'd0, 0);
    step(0, 1, 0, 0, 4'd0, 0, 4'd9, 1);
    step(0, 1, 0, 0, 4'd0, 0, 4'd8, 0);

    // Saturate at both ends
    step(0, 0, 1, 1, 4'd7, 1, 4'd7, 0);
    step(0, 1, 1, 0, 4'd0, 1, 4'd8, 0);
    step(0, 1, 1, 0, 4'd0, 1, 4'd9, 0);
    step(0, 1, 1, 0, 4'd0, 1, 4'd9, 0);
    step(0, 1, 1, 0, 4'd0, 1, 4'd9, 0);
    step(0, 1, 1, 0, 4'd0, 1, 4'd9, 0);
    step(0, 0, 0, 1, 4'd1, 1, 4'd1, 0);
    step(0, 1, 0, 0, 4'd0, 1, 4'd0, 0);
    step(0, 1, 0, 0, 4'd0, 1, 4'd0, 0);
    step(0, 0, 0, 0, 4'd0, 1, 4'd0, 0);

    // Load beats enable; out-of-range load clamps to MAX
    step(0, 1, 1, 1, 4'd4,  0, 4'd4, 0);
    step(0, 1, 1, 1, 4'd13, 0, 4'd9, 0);
    step(0, 0, 1, 0, 4'd0,  0, 4'd9, 0);
    step(0, 1, 1, 0, 4'd0,  0, 4'd0, 1);
    step(0, 0, 1, 0, 4'd0,  0, 4'd0, 0);

    // Asynchronous clear between edges while at 6
    step(0, 0, 1, 1, 4'd6, 0, 4'd6, 0);
    @(posedge clk);
    #3;
    i_load = 1'b0; i_en = 1'b1; i_up = 1'b1; i_clr = 1'b1;
    #1;
    chk("aclr_count", 16'(o_count), 16'd0);
    chk("aclr_wrap",  16'(o_wrap),  16'd0);
    step(1, 1, 1, 0, 4'd0, 0, 4'd0, 0);
    step(1, 1, 1, 0, 4'd0, 0, 4'd0, 0);
    step(0, 1, 1, 0, 4'd0, 0, 4'd1, 0);
    step(0, 1, 1, 0, 4'd0, 0, 4'd2, 0);
    step(0, 1, 1, 0, 4'd0, 0, 4'd3, 0);

    // Cascade 00..99 and back to 00
    chk("casc_rst_lo", 16'(lo_count), 16'd0);
    chk("casc_rst_hi", 16'(hi_count), 16'd0);
    for (int n = 1; n <= 101; n++)
      cstep(0, 1, 4'(n % 10), 4'((n / 10) % 10), (n == 100));

    repeat (3) @(posedge clk);
    #2;
    chk("sb_drain", 16'(sbq.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
